// File: rtl/multiplier_rr_scheduler.sv
// rtl/multiplier_rr_scheduler.sv - round-robin scheduler sharing one unsigned multiplier (optional MULT_SCHED_PERF_EN adds op_count)
module multiplier_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mult_A,
    output logic [WIDTH-1:0]         mult_B,
    input  logic [2*WIDTH-1:0]       mult_product,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic [ID_W-1:0]          resp_id,
`ifdef MULT_SCHED_PERF_EN
    output logic [15:0]              op_count,
`endif
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      last_grant_q;
    logic [WIDTH-1:0]     mult_a_q;
    logic [WIDTH-1:0]     mult_b_q;
    logic                 resp_valid_q;
    logic [2*WIDTH-1:0]   resp_product_q;
    logic [ID_W-1:0]      resp_id_q;
`ifdef MULT_SCHED_PERF_EN
    logic [15:0]          op_count_q;
`endif

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    int                   cand;
    logic                 req_accept;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    // Rotating priority search: start just after the last served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Grant is offered only while idle and out of reset; it never looks at any ready.
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == S_IDLE) && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    assign req_accept = |(req_valid & req_ready);
    assign sel_a      = req_a[grant_idx*WIDTH +: WIDTH];
    assign sel_b      = req_b[grant_idx*WIDTH +: WIDTH];

    // Main FSM: capture operands, latch the shared multiplier result, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            mult_a_q       <= '0;
            mult_b_q       <= '0;
            resp_valid_q   <= 1'b0;
            resp_product_q <= '0;
            resp_id_q      <= '0;
`ifdef MULT_SCHED_PERF_EN
            op_count_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_accept) begin
                        mult_a_q  <= sel_a;
                        mult_b_q  <= sel_b;
                        resp_id_q <= grant_idx;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    resp_product_q <= mult_product;
                    resp_valid_q   <= 1'b1;
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        last_grant_q <= resp_id_q;
                        state_q      <= S_IDLE;
`ifdef MULT_SCHED_PERF_EN
                        op_count_q   <= op_count_q + 16'd1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mult_A       = mult_a_q;
    assign mult_B       = mult_b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_product = resp_product_q;
    assign resp_id      = resp_id_q;
    assign busy         = (state_q != S_IDLE);
`ifdef MULT_SCHED_PERF_EN
    assign op_count     = op_count_q;
`endif

endmodule
